// File: rtl/mem_axi_pkg.sv
// Shared definitions for the PicoRV32-native to AXI4-Lite bridge: response codes,
// FSM state encoding and AxPROT bit positions.
package mem_axi_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam int unsigned ProtPrivBit  = 0;
    localparam int unsigned ProtNsecBit  = 1;
    localparam int unsigned ProtInstrBit = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

endpackage

// File: rtl/mem_axi_watchdog.sv
// Transaction watchdog: counts busy cycles since the bridge left IDLE and flags expiry.
// Instantiated by mem_axi_bridge only when MEM_AXI_BRIDGE_TIMEOUT_EN is defined.
module mem_axi_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] Limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    // Saturates at the limit so expiry stays visible until the transaction ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 16'd0;
        end else if (clear) begin
            count_q <= 16'd0;
        end else if (run && (count_q != Limit)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expired = run && (count_q == Limit);

endmodule

// File: rtl/mem_axi_bridge.sv
// PicoRV32 native memory interface to single-outstanding AXI4-Lite master.
// Define MEM_AXI_BRIDGE_TIMEOUT_EN to build in the transaction watchdog.
module mem_axi_bridge
    import mem_axi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [2:0]  m_awprot,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [2:0]  m_arprot,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    state_e state_q, state_d;

    logic        abort;
    logic        busy;
    logic        expired;
    logic        aw_clear, w_clear;
    logic        b_hs, ar_hs, r_hs;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic [2:0]  arprot_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_d;
    logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic        ready_d, err_d;

    assign busy     = state_q inside {StWrReq, StWrResp, StRdReq, StRdResp};
    assign aw_clear = ~m_awvalid | m_awready;
    assign w_clear  = ~m_wvalid | m_wready;
    assign b_hs     = m_bvalid & m_bready;
    assign ar_hs    = m_arvalid & m_arready;
    assign r_hs     = m_rvalid & m_rready;

`ifdef MEM_AXI_BRIDGE_TIMEOUT_EN
    mem_axi_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == StIdle),
        .run    (busy),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            StIdle:   if (mem_valid) state_d = (|mem_wstrb) ? StWrReq : StRdReq;
            StWrReq:  if (aw_clear && w_clear) state_d = StWrResp;
            StWrResp: if (b_hs) state_d = StDone;
            StRdReq:  if (ar_hs) state_d = StRdResp;
            StRdResp: if (r_hs) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // A handshake that lets the FSM advance this cycle beats the watchdog.
        if (busy && expired && (state_d == state_q)) begin
            state_d = StDone;
            abort   = 1'b1;
        end
    end

    always_comb begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_d == StWrReq) begin
            awvalid_d = (state_q == StIdle) | (m_awvalid & ~m_awready);
            wvalid_d  = (state_q == StIdle) | (m_wvalid & ~m_wready);
        end
        bready_d  = (state_d == StWrResp);
        arvalid_d = (state_d == StRdReq);
        rready_d  = (state_d == StRdResp);
        ready_d   = (state_d == StDone);

        addr_d   = addr_q;
        wdata_d  = m_wdata;
        wstrb_d  = m_wstrb;
        arprot_d = m_arprot;
        if (state_d == StIdle) begin
            addr_d   = 32'h0;
            wdata_d  = 32'h0;
            wstrb_d  = 4'h0;
            arprot_d = 3'b000;
        end else if (state_q == StIdle) begin
            addr_d                 = mem_addr;
            wdata_d                = mem_wdata;
            wstrb_d                = mem_wstrb;
            arprot_d               = 3'b000;
            arprot_d[ProtInstrBit] = mem_instr;
        end

        resp_d = resp_q;
        if (b_hs) resp_d = m_bresp;
        if (r_hs) resp_d = m_rresp;
        err_d = (state_d == StDone) && (abort || (resp_d != RespOkay));

        rdata_d = mem_rdata;
        if (r_hs) begin
            rdata_d = m_rdata;
        end else if (abort && (state_q inside {StRdReq, StRdResp})) begin
            rdata_d = ERR_RDATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= 32'h0;
            m_wdata   <= 32'h0;
            m_wstrb   <= 4'h0;
            m_arprot  <= 3'b000;
            resp_q    <= RespOkay;
            mem_rdata <= 32'h0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            m_wdata   <= wdata_d;
            m_wstrb   <= wstrb_d;
            m_arprot  <= arprot_d;
            resp_q    <= resp_d;
            mem_rdata <= rdata_d;
            mem_ready <= ready_d;
            bus_err   <= err_d;
            m_awvalid <= awvalid_d;
            m_wvalid  <= wvalid_d;
            m_bready  <= bready_d;
            m_arvalid <= arvalid_d;
            m_rready  <= rready_d;
        end
    end

    // One address register feeds both channels so downstream decode always agrees.
    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_awprot = 3'b000;

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Converts the PicoRV32 native memory interface (mem_valid/mem_ready) into single-beat AXI4-Lite master transactions and sits directly upstream of the system AXI interconnect, driving its m_* port set. It issues exactly one outstanding transaction, either read or write. Write address and write data are handed over independently. It returns read data and completion to the core. An optional watchdog aborts transactions that a slave never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles a transaction may spend outside IDLE before abort (only with the watchdog compiled in); range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF: value returned on mem_rdata on timeout abort.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  core request.
- mem_instr  in  1  instruction fetch flag.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- bus_err  out  1  one-cycle pulse with mem_ready when resp!=OKAY or timeout.
- m_awaddr/m_awvalid/m_awready, m_awprot (out 3): AW channel.
- m_wdata/m_wstrb/m_wvalid/m_wready: W channel.
- m_bresp/m_bvalid/m_bready: B channel.
- m_araddr/m_arvalid/m_arready, m_arprot (out 3): AR channel.
- m_rdata/m_rresp/m_rvalid/m_rready: R channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: when mem_valid=1, capture mem_addr, mem_wdata, mem_wstrb and mem_instr.
  - Go to WR_REQ if the captured wstrb is non-zero, else RD_REQ.
- Address drive:
  - m_awaddr and m_araddr are both driven with the captured address for the whole transaction.
  - Both are 0 in IDLE.
  - This keeps the downstream address decode consistent on both channels.
- WR_REQ:
  - m_awvalid and m_wvalid assert together.
  - Each drops independently after its own handshake.
  - Leave for WR_RESP when both handshakes are done, whether in the same cycle or different cycles.
- WR_RESP: m_bready=1; on the B handshake, latch bresp and go to DONE.
- RD_REQ: m_arvalid=1; on the AR handshake, go to RD_RESP.
- RD_RESP: m_rready=1; on the R handshake, latch rdata and rresp and go to DONE.
- DONE:
  - mem_ready=1 for exactly one cycle.
  - bus_err=1 if the latched resp!=2'b00.
  - Next state is IDLE; mem_valid is not sampled in DONE.
- Protection signals: m_awprot=3'b000; m_arprot={mem_instr,2'b00}.
- m_wstrb and m_wdata carry the captured values.
- mem_rdata:
  - Holds the last read value, including error-response data.
  - After a write, holds the previous value.
- mem_valid dropping mid-transaction (illegal): the AXI transaction still completes and mem_ready still pulses.
- Handshakes follow AXI rules: a valid, once asserted, is never withdrawn before its ready, except on timeout abort.

## Timing
- Reset values: mem_ready=0, bus_err=0, mem_rdata=0, all m_*valid=0, m_bready=0, m_rready=0, addresses/wdata/wstrb/prot=0, state IDLE.
- Reset mid-transaction drops every valid and ready immediately (asynchronously); there is no completion pulse.
- Minimum latency: mem_valid sampled at edge 0, so the request valids are high in cycle 1.
  - With zero-wait slaves (ready in cycle 1, response in cycle 2), mem_ready is high in cycle 3.
  - This holds for both reads and writes.
- All outputs are registered; no combinational path exists from an m_* input to an m_* output.
- Back-to-back: after mem_ready, the earliest next request is sampled 1 cycle later (in IDLE).

## Configuration
- MEM_AXI_BRIDGE_TIMEOUT_EN defined (watchdog on):
  - A 16-bit counter clears on leaving IDLE and increments every cycle in the request/response states.
  - When it reaches TIMEOUT_CYCLES-1 without completion, all valids and readies drop at the next edge and the FSM enters DONE.
  - In DONE: mem_ready=1, bus_err=1, and mem_rdata=ERR_RDATA for reads (unchanged for writes).
  - A handshake completing in the same cycle as the timeout wins; the transaction completes normally.
- MEM_AXI_BRIDGE_TIMEOUT_EN undefined: no counter; the bridge waits forever; bus_err only reflects resp.

## Structure
- Shared package mem_axi_pkg holds:
  - AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR);
  - the state encoding for the six states;
  - the prot bit positions.
- One sub-module: mem_axi_watchdog.
  - Contains the counter plus the expired flag.
  - Inputs: clk, reset, clear, run. Output: expired.
  - It is only instantiated when MEM_AXI_BRIDGE_TIMEOUT_EN is defined.

## Test plan
- Zero-wait write: addr 0x1000_0004, wdata 0xA5A5_0001, wstrb 4'hF, bresp OKAY -> AW/W seen in cycle 1, mem_ready in cycle 3, bus_err=0.
- Split write: awready in cycle 1, wready delayed until cycle 4 -> m_awvalid low from cycle 2, m_wvalid held until cycle 4, then WR_RESP.
- Instruction read: addr 0x0000_0100, mem_instr=1, rdata 0x1234_5678, rvalid 2 cycles late -> m_arprot=3'b100, mem_rdata=0x1234_5678 on the mem_ready cycle.
- Error response: read at 0x6000_0000 answered with DECERR and rdata 0 -> mem_ready=1, bus_err=1, mem_rdata=0.
- Timeout (macro on, TIMEOUT_CYCLES=8): arready never asserts -> m_arvalid drops after 8 cycles, mem_ready=1, bus_err=1, mem_rdata=0xDEAD_BEEF.
- Reset asserted in WR_RESP -> all valids, readies and mem_ready are 0 immediately; a new read after release completes normally.
